// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: latches a packed digit vector and drives one
// common-anode digit at a time with blanking gaps. Optional macro: LEADING_ZERO_SUPPRESS_EN.
module display_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              digit_out,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_tick
);

    localparam int unsigned DATA_W  = 4 * NUM_DIGITS;
    localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     shadow_q, shadow_d;
    logic [DATA_W-1:0]     frame_q, frame_d;
    logic [NUM_DIGITS-1:0] anode_d;
    logic [3:0]            digit_d;
    logic                  tick_d;
    logic                  suppress;

    // Next-state and next-output logic; outputs are derived from the next register
    // values so anode_n/digit_out/frame_tick line up with the state on the same edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        shadow_d = load ? digits_in : shadow_q;
        anode_d  = '1;
        digit_d  = 4'd0;
        tick_d   = 1'b0;
        suppress = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (enable) begin
                    state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    if (idx_q == '0) begin
                        frame_d = shadow_q;
                        tick_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Disabling goes dark on the next edge and restarts the scan from digit 0.
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            frame_d = frame_q;
            tick_d  = 1'b0;
        end

        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_d) begin
                digit_d = frame_d[4*i +: 4];
            end
        end

`ifdef LEADING_ZERO_SUPPRESS_EN
        // Blank a slot when it and every more-significant digit are zero; slot 0 always shows.
        begin
            logic upper_nz;
            upper_nz = 1'b0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (IDX_W'(i) >= idx_d && frame_d[4*i +: 4] != 4'd0) begin
                    upper_nz = 1'b1;
                end
            end
            suppress = (idx_d != '0) && !upper_nz;
        end
`else
        suppress = 1'b0;
`endif

        if (state_d == ST_DRIVE && !suppress) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (IDX_W'(i) == idx_d) begin
                    anode_d[i] = 1'b0;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            frame_q    <= '0;
            anode_n    <= '1;
            digit_out  <= 4'd0;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            frame_q    <= frame_d;
            anode_n    <= anode_d;
            digit_out  <= digit_d;
            frame_tick <= tick_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
// Honors LEADING_ZERO_SUPPRESS_EN when defined at compile time.
module tb_display_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  digit_out;
    logic [3:0]  anode_n;
    logic        frame_tick;

    int checks;
    int failures;

    display_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .digits_in (digits_in),
        .digit_out (digit_out),
        .anode_n   (anode_n),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit later. load is a 1-cycle strobe.
    task automatic step();
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Two blank cycles followed by an 8-cycle drive slot for digit idx.
    task automatic run_digit(input int idx, input logic [3:0] dig, input bit lit);
        logic [3:0] exp_an;
        for (int b = 0; b < 2; b++) begin
            step();
            chk($sformatf("blank_an[%0d]", idx), 32'(anode_n), 32'hF);
            chk($sformatf("blank_tick[%0d]", idx), 32'(frame_tick), 32'h0);
        end
        exp_an = 4'hF;
        if (lit) exp_an[idx] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("drive_an[%0d]", idx), 32'(anode_n), 32'(exp_an));
            if (lit) chk($sformatf("drive_dig[%0d]", idx), 32'(digit_out), 32'(dig));
            chk($sformatf("drive_tick[%0d]", idx), 32'(frame_tick), (idx == 0 && k == 0) ? 32'h1 : 32'h0);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0000;
        step();
        step();
        chk("rst_an", 32'(anode_n), 32'hF);
        chk("rst_dig", 32'(digit_out), 32'h0);
        chk("rst_tick", 32'(frame_tick), 32'h0);

        // Basic scan of 4321, two full frames; 9999 loaded while idx=2 of frame 2
        reset     = 1'b0;
        enable    = 1'b1;
        load      = 1'b1;
        digits_in = 16'h4321;
        run_digit(0, 4'h1, 1'b1);
        run_digit(1, 4'h2, 1'b1);
        run_digit(2, 4'h3, 1'b1);
        run_digit(3, 4'h4, 1'b1);
        run_digit(0, 4'h1, 1'b1);
        run_digit(1, 4'h2, 1'b1);
        load      = 1'b1;
        digits_in = 16'h9999;
        run_digit(2, 4'h3, 1'b1);
        run_digit(3, 4'h4, 1'b1);
        run_digit(0, 4'h9, 1'b1);
        run_digit(1, 4'h9, 1'b1);
        run_digit(2, 4'h9, 1'b1);
        run_digit(3, 4'h9, 1'b1);

        // Enable drops mid-DRIVE of digit 0
        step();
        step();
        step();
        step();
        chk("pre_dis_an", 32'(anode_n), 32'hE);
        enable = 1'b0;
        step();
        chk("dis_an", 32'(anode_n), 32'hF);
        chk("dis_tick", 32'(frame_tick), 32'h0);
        step();
        step();
        chk("dis_hold_an", 32'(anode_n), 32'hF);
        enable = 1'b1;
        run_digit(0, 4'h9, 1'b1);
        run_digit(1, 4'h9, 1'b1);

        // Reset mid-DRIVE of digit 2 clears shadow; restart shows zeros
        step();
        step();
        step();
        step();
        chk("pre_rst_an", 32'(anode_n), 32'hB);
        reset = 1'b1;
        step();
        chk("mid_rst_an", 32'(anode_n), 32'hF);
        chk("mid_rst_dig", 32'(digit_out), 32'h0);
        chk("mid_rst_tick", 32'(frame_tick), 32'h0);
        reset = 1'b0;
`ifdef LEADING_ZERO_SUPPRESS_EN
        run_digit(0, 4'h0, 1'b1);
        run_digit(1, 4'h0, 1'b0);
        run_digit(2, 4'h0, 1'b0);
        run_digit(3, 4'h0, 1'b0);
        load      = 1'b1;
        digits_in = 16'h0050;
        run_digit(0, 4'h0, 1'b1);
        run_digit(1, 4'h5, 1'b1);
        run_digit(2, 4'h0, 1'b0);
        run_digit(3, 4'h0, 1'b0);
`else
        run_digit(0, 4'h0, 1'b1);
        run_digit(1, 4'h0, 1'b1);
        run_digit(2, 4'h0, 1'b1);
        run_digit(3, 4'h0, 1'b1);
        load      = 1'b1;
        digits_in = 16'h0050;
        run_digit(0, 4'h0, 1'b1);
        run_digit(1, 4'h5, 1'b1);
        run_digit(2, 4'h0, 1'b1);
        run_digit(3, 4'h0, 1'b1);
`endif

        // Codes above 9 pass straight through
        load      = 1'b1;
        digits_in = 16'hFEDC;
        run_digit(0, 4'hC, 1'b1);
        run_digit(1, 4'hD, 1'b1);
        run_digit(2, 4'hE, 1'b1);
        run_digit(3, 4'hF, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
